// File: rtl/booth.sv
// Three-stage pipelined 32x32 signed multiplier built on radix-4 Booth recoding.
// Stages: operand capture, partial products summed in four groups, final add.
module booth (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] P
);

  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [63:0] group_reg  [4];
  logic [63:0] group_next [4];
  logic [63:0] pp         [16];
  logic [63:0] sum_next;
  logic [32:0] a_ext;
  logic [32:0] b_ext;

  assign a_ext = {a_reg[31], a_reg};
  // Appending a zero below bit 0 supplies the implicit B[-1] of the first triple.
  assign b_ext = {b_reg, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      a_reg <= A;
      b_reg <= B;
    end
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_pp
      localparam int SHIFT = 2 * gi;
      logic [2:0]  trip;
      logic        is_zero;
      logic        is_two;
      logic        is_neg;
      logic [32:0] mag;
      logic [63:0] mag_ext;
      logic [63:0] pp_raw;

      assign trip    = b_ext[2*gi+2 : 2*gi];
      assign is_zero = (trip == 3'b000) || (trip == 3'b111);
      assign is_two  = (trip == 3'b011) || (trip == 3'b100);
      assign is_neg  = trip[2];

      always_comb begin
        mag = '0;
        if (!is_zero) begin
          mag = is_two ? {a_ext[31:0], 1'b0} : a_ext;
        end
      end

      // Negate after widening: -2 * (-2^31) needs more than 33 bits.
      assign mag_ext = {{31{mag[32]}}, mag};
      assign pp_raw  = (is_neg && !is_zero) ? (~mag_ext + 64'd1) : mag_ext;
      assign pp[gi]  = pp_raw << SHIFT;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_grp
      assign group_next[gi] = pp[4*gi] + pp[4*gi+1] + pp[4*gi+2] + pp[4*gi+3];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        group_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        group_reg[i] <= group_next[i];
      end
    end
  end

  assign sum_next = group_reg[0] + group_reg[1] + group_reg[2] + group_reg[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      P <= '0;
    end else begin
      P <= sum_next;
    end
  end

endmodule

// File: tb/tb_booth.sv
// Self-checking bench for booth: directed vector table, latency/throughput and
// reset sequences, then randomized operands against a plain-arithmetic model.
module tb_booth;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] P;

  int total;
  int bad;

  booth dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: P=%h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: P=%h", name, act);
    end
  endtask

  // Returns 1 ns after the next rising edge, so outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    return sa * sb;
  endfunction

  function automatic logic [31:0] rand_op();
    int sel;
    sel = $urandom_range(0, 15);
    case (sel)
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] q [$];
    total = 0;
    bad   = 0;

    vecs[0]  = '{32'd5,         -32'sd5,       64'hFFFF_FFFF_FFFF_FFE7};
    vecs[1]  = '{-32'sd5,       -32'sd5,       64'd25};
    vecs[2]  = '{-32'sd5,       32'd5,         64'hFFFF_FFFF_FFFF_FFE7};
    vecs[3]  = '{32'd5,         32'd5,         64'd25};
    vecs[4]  = '{32'd0,         -32'sd5,       64'd0};
    vecs[5]  = '{32'd1,         -32'sd5,       64'hFFFF_FFFF_FFFF_FFFB};
    vecs[6]  = '{32'd8,         32'd6,         64'd48};
    vecs[7]  = '{-32'sd12,      32'd6,         64'hFFFF_FFFF_FFFF_FFB8};
    vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[9]  = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
    vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1};
    vecs[11] = '{32'd12345,     32'd0,         64'd0};
    vecs[12] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    vecs[13] = '{32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};

    // Reset state, including while clocks run with reset held.
    rst_n = 1'b0;
    A = 32'd123;
    B = 32'd456;
    #2;
    check("reset_initial", P, 64'd0);
    repeat (3) tick();
    check("reset_held", P, 64'd0);
    #2;
    rst_n = 1'b1;
    tick();

    // Directed table, each pair held 10 cycles.
    for (int i = 0; i < 14; i++) begin
      A = vecs[i].a;
      B = vecs[i].b;
      repeat (10) tick();
      check($sformatf("vec%0d a=%h b=%h", i, vecs[i].a, vecs[i].b), P, vecs[i].p);
    end

    // Back-to-back operands: one product per edge after a two-edge delay.
    A = 32'd3;          B = 32'd4;           tick();
    A = -32'sd7;        B = 32'd9;           tick();
    A = 32'd100000;     B = -32'sd100000;    tick();
    check("stream_12", P, 64'd12);
    A = 32'd0;          B = 32'd0;           tick();
    check("stream_m63", P, 64'hFFFF_FFFF_FFFF_FFC1);
    tick();
    check("stream_m1e10", P, 64'hFFFF_FFFD_ABF4_1C00);
    tick();
    check("stream_drain", P, 64'd0);

    // Reset between edges with products in flight.
    A = 32'd1000;  B = 32'd1000;  tick();
    A = 32'd2000;  B = 32'd3000;  tick();
    A = 32'd77;    B = 32'd11;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", P, 64'd0);
    A = 32'd6;
    B = 32'd7;
    tick();
    check("reset_held_clk", P, 64'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check("release_edge1", P, 64'd0);
    tick();
    check("release_edge2", P, 64'd0);
    tick();
    check("release_edge3", P, 64'd42);
    tick();
    check("release_edge4", P, 64'd42);

    // Random stream, changing every cycle, aligned to the three-edge latency.
    for (int n = 0; n < 10002; n++) begin
      A = rand_op();
      B = rand_op();
      q.push_back(model(A, B));
      tick();
      if (q.size() == 3) begin
        total++;
        if (P !== q[0]) begin
          bad++;
          $display("FAIL random n=%0d: P=%h expected %h", n, P, q[0]);
        end
        void'(q.pop_front());
      end
      if (n % 1000 == 999) begin
        $display("random progress: %0d pairs, bad so far %0d", n + 1, bad);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth.md
BOOTH -- requirements
Module: booth

Interface
REQ-001 Parameters: none; all widths fixed as stated below.
REQ-002 clk  input  1  rising-edge clock for all sequential logic.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 A  input  32  multiplicand, two's-complement signed.
REQ-005 B  input  32  multiplier, two's-complement signed.
REQ-006 P  output  64  registered signed product A*B, two's-complement.
REQ-007 The block SHALL have no start or valid handshake; A and B SHALL be sampled on every rising clk edge, and P SHALL continuously track them.

Function
REQ-008 The block SHALL compute the exact signed 64-bit product; overflow is impossible at 64 bits, so no truncation or saturation SHALL occur.
REQ-009 The block SHALL use radix-4 (modified) Booth recoding of B:
- 16 digits d_i from the bit triple (B[2i+1], B[2i], B[2i-1]), i = 0..15, with B[-1] = 0.
- Digit mapping: 000/111 -> 0; 001/010 -> +1; 011 -> +2; 100 -> -2; 101/110 -> -1.
REQ-010 Partial product i SHALL be d_i*A, sign-extended to 64 bits and shifted left by 2i. Negative digits SHALL be formed as bitwise inversion plus one; +/-2A SHALL be formed by a 1-bit left shift of the 33-bit sign-extended A.
REQ-011 Stage 1: on each rising edge, register A and B into input registers a_q and b_q.
REQ-012 Stage 2: Booth-recode b_q, generate the 16 partial products, and sum them in four groups of four (pp0-3, pp4-7, pp8-11, pp12-15). Register the four 64-bit group sums.
REQ-013 Stage 3: add the four group sums and register the result into P.
REQ-014 Latency: operands present at rising edge n SHALL appear on P after rising edge n+2, i.e. 3 edges including the sampling edge.
REQ-015 Throughput: one product per cycle. Operands changing every cycle SHALL produce a matching product stream on P, each delayed by the fixed latency.
REQ-016 P SHALL change only on rising clk edges or on reset assertion; there SHALL be no combinational path from A or B to P.
REQ-017 Boundary cases SHALL be exact:
- A or B = 0 gives 0.
- 0x80000000 * 0x80000000 = 0x4000000000000000.
- 0x7FFFFFFF * 0x80000000 = 0xC000000080000000.
- 0xFFFFFFFF * 0xFFFFFFFF = 1.

Reset
REQ-018 While rst_n = 0, a_q, b_q, all group-sum registers and P SHALL be forced to 0 immediately, independent of clk.
REQ-019 Reset asserted mid-computation SHALL discard all in-flight products.
REQ-020 After rst_n rises, the first valid product SHALL appear at the third rising edge after release. P SHALL read 0 until then, because the pipeline holds zeros.

Verification
REQ-021 Signed mixes, each operand pair held 10 cycles before P is checked:
- A=5, B=-5 -> P=0xFFFFFFFFFFFFFFE7 (-25).
- A=-5, B=-5 -> P=25.
- A=-5, B=5 -> P=-25.
- A=5, B=5 -> P=25.
REQ-022 Identities, each held 10 cycles:
- A=0, B=-5 -> P=0.
- A=1, B=-5 -> P=0xFFFFFFFFFFFFFFFB.
- A=8, B=6 -> P=48.
- A=-12, B=6 -> P=0xFFFFFFFFFFFFFFB8 (-72).
REQ-023 Extremes:
- A=B=0x80000000 -> P=0x4000000000000000.
- A=0x7FFFFFFF, B=0x80000000 -> P=0xC000000080000000.
REQ-024 Latency and throughput: apply (3,4), (-7,9), (100000,-100000) on consecutive edges. P SHALL show 12, -63 and -10000000000 on three consecutive edges, the first 2 edges after the first operand edge.
REQ-025 Reset: assert rst_n=0 between clk edges while products are in flight. P SHALL read 0 at once. After release with A=6, B=7 held, P SHALL read 0 for two edges, then 42 from the third edge.
REQ-026 Random: at least 10000 random signed operand pairs, checked against a 64-bit signed reference model with latency alignment, with zero mismatches.
